// File: rtl/elevator_fsm.sv
// Four-floor elevator controller: locates the car, serves latched requests with a
// direction-preferring sweep, and times the door. Optional home return: ELEV_HOME_RETURN_EN.
module elevator_fsm #(
  parameter int DOOR_CYCLES = 8,
  parameter int IDLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       S4,
  input  logic       U1,
  input  logic       U2,
  input  logic       U3,
  input  logic       U4,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       F1,
  input  logic       F2,
  input  logic       F3,
  input  logic       F4,
  output logic       up,
  output logic       down,
  output logic       stop,
  output logic       open_door,
  output logic [1:0] floor,
  output logic [3:0] clr
);

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_MOVE_UP   = 3'd2;
  localparam logic [2:0] ST_MOVE_DOWN = 3'd3;
  localparam logic [2:0] ST_DOOR      = 3'd4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    case (f)
      2'd0:    above_mask = 4'b1110;
      2'd1:    above_mask = 4'b1100;
      2'd2:    above_mask = 4'b1000;
      default: above_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    case (f)
      2'd0:    below_mask = 4'b0000;
      2'd1:    below_mask = 4'b0001;
      2'd2:    below_mask = 4'b0011;
      default: below_mask = 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] floor_onehot(input logic [1:0] f);
    floor_onehot = 4'b0001 << f;
  endfunction

  logic [2:0]    state_r, state_s;
  logic [1:0]    floor_r, floor_s, cur_s, sens_idx_s;
  logic          dir_r, dir_s;
  logic [DW-1:0] door_cnt_r, door_cnt_s;
  logic          up_r, up_s, down_r, down_s, stop_r, stop_s, open_r, open_s;
  logic [3:0]    clr_r, clr_s;
  logic [3:0]    sens_s, u_s, d_s, f_s, pend_s;
  logic          sens_one_s, home_eff_s;

`ifdef ELEV_HOME_RETURN_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] idle_cnt_r, idle_cnt_s;
  logic          home_r, home_s;
  // A pending request cancels the home trip so it is served normally.
  assign home_eff_s = home_r && (pend_s == 4'b0000);
`else
  assign home_eff_s = 1'b0;
`endif

  assign sens_s     = {S4, S3, S2, S1};
  assign u_s        = {U4, U3, U2, U1};
  assign d_s        = {D4, D3, D2, D1};
  assign f_s        = {F4, F3, F2, F1};
  assign pend_s     = u_s | d_s | f_s;
  assign sens_one_s = (sens_s != 4'b0000) && ((sens_s & (sens_s - 4'd1)) == 4'b0000);

  // Sensor index decode; only meaningful when exactly one sensor is high.
  always_comb begin
    case (sens_s)
      4'b0010: sens_idx_s = 2'd1;
      4'b0100: sens_idx_s = 2'd2;
      4'b1000: sens_idx_s = 2'd3;
      default: sens_idx_s = 2'd0;
    endcase
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_s    = state_r;
    floor_s    = floor_r;
    dir_s      = dir_r;
    door_cnt_s = door_cnt_r;
    cur_s      = floor_r;
    up_s       = 1'b0;
    down_s     = 1'b0;
    stop_s     = 1'b1;
    open_s     = 1'b0;
    clr_s      = 4'b0000;
`ifdef ELEV_HOME_RETURN_EN
    idle_cnt_s = '0;
    home_s     = home_eff_s;
`endif
    case (state_r)
      ST_INIT: begin
        if (sens_one_s) begin
          floor_s = sens_idx_s;
          state_s = ST_IDLE;
        end else begin
          down_s = 1'b1;
          stop_s = 1'b0;
        end
      end
      ST_IDLE: begin
        cur_s   = sens_one_s ? sens_idx_s : floor_r;
        floor_s = cur_s;
        if (pend_s[cur_s]) begin
          state_s    = ST_DOOR;
          door_cnt_s = '0;
          open_s     = 1'b1;
          clr_s      = floor_onehot(cur_s);
        end else if (((dir_r == DIR_UP) && ((pend_s & above_mask(cur_s)) != 4'b0000)) ||
                     ((dir_r == DIR_DOWN) && ((pend_s & below_mask(cur_s)) == 4'b0000) &&
                      ((pend_s & above_mask(cur_s)) != 4'b0000))) begin
          state_s = ST_MOVE_UP;
          dir_s   = DIR_UP;
          up_s    = 1'b1;
          stop_s  = 1'b0;
        end else if ((pend_s & below_mask(cur_s)) != 4'b0000) begin
          state_s = ST_MOVE_DOWN;
          dir_s   = DIR_DOWN;
          down_s  = 1'b1;
          stop_s  = 1'b0;
        end else begin
`ifdef ELEV_HOME_RETURN_EN
          if (cur_s != 2'd0) begin
            if (idle_cnt_r == IW'(IDLE_CYCLES - 1)) begin
              state_s = ST_MOVE_DOWN;
              dir_s   = DIR_DOWN;
              down_s  = 1'b1;
              stop_s  = 1'b0;
              home_s  = 1'b1;
            end else begin
              idle_cnt_s = idle_cnt_r + IW'(1);
            end
          end else begin
            idle_cnt_s = '0;
          end
`else
          state_s = ST_IDLE;
`endif
        end
      end
      ST_MOVE_UP: begin
        dir_s  = DIR_UP;
        up_s   = 1'b1;
        stop_s = 1'b0;
        if (sens_one_s && (sens_idx_s != floor_r)) begin
          floor_s = sens_idx_s;
          if (f_s[sens_idx_s] || u_s[sens_idx_s] || (sens_idx_s == 2'd3) ||
              ((pend_s & above_mask(sens_idx_s)) == 4'b0000)) begin
            state_s    = ST_DOOR;
            door_cnt_s = '0;
            up_s       = 1'b0;
            stop_s     = 1'b1;
            open_s     = 1'b1;
            clr_s      = floor_onehot(sens_idx_s);
          end else begin
            state_s = ST_MOVE_UP;
          end
        end else begin
          state_s = ST_MOVE_UP;
        end
      end
      ST_MOVE_DOWN: begin
        dir_s  = DIR_DOWN;
        down_s = 1'b1;
        stop_s = 1'b0;
        if (sens_one_s && (sens_idx_s != floor_r)) begin
          floor_s = sens_idx_s;
          if (home_eff_s) begin
            // Home trip ends at the ground floor without opening the door.
            if (sens_idx_s == 2'd0) begin
              state_s = ST_IDLE;
              down_s  = 1'b0;
              stop_s  = 1'b1;
`ifdef ELEV_HOME_RETURN_EN
              home_s  = 1'b0;
`endif
            end else begin
              state_s = ST_MOVE_DOWN;
            end
          end else if (f_s[sens_idx_s] || d_s[sens_idx_s] || (sens_idx_s == 2'd0) ||
                       ((pend_s & below_mask(sens_idx_s)) == 4'b0000)) begin
            state_s    = ST_DOOR;
            door_cnt_s = '0;
            down_s     = 1'b0;
            stop_s     = 1'b1;
            open_s     = 1'b1;
            clr_s      = floor_onehot(sens_idx_s);
          end else begin
            state_s = ST_MOVE_DOWN;
          end
        end else begin
          state_s = ST_MOVE_DOWN;
        end
      end
      ST_DOOR: begin
        if (door_cnt_r == DW'(DOOR_CYCLES - 1)) begin
          state_s = ST_IDLE;
        end else begin
          door_cnt_s = door_cnt_r + DW'(1);
          open_s     = 1'b1;
          clr_s      = floor_onehot(floor_r);
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_INIT;
      floor_r    <= 2'd0;
      dir_r      <= DIR_UP;
      door_cnt_r <= '0;
      up_r       <= 1'b0;
      down_r     <= 1'b0;
      stop_r     <= 1'b1;
      open_r     <= 1'b0;
      clr_r      <= 4'b0000;
`ifdef ELEV_HOME_RETURN_EN
      idle_cnt_r <= '0;
      home_r     <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      floor_r    <= floor_s;
      dir_r      <= dir_s;
      door_cnt_r <= door_cnt_s;
      up_r       <= up_s;
      down_r     <= down_s;
      stop_r     <= stop_s;
      open_r     <= open_s;
      clr_r      <= clr_s;
`ifdef ELEV_HOME_RETURN_EN
      idle_cnt_r <= idle_cnt_s;
      home_r     <= home_s;
`endif
    end
  end

  assign up        = up_r;
  assign down      = down_r;
  assign stop      = stop_r;
  assign open_door = open_r;
  assign floor     = floor_r;
  assign clr       = clr_r;

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed bench for elevator_fsm: each task drives one scenario and checks inline.
module tb_elevator_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       S1 = 1'b0, S2 = 1'b0, S3 = 1'b0, S4 = 1'b0;
  logic       U1 = 1'b0, U2 = 1'b0, U3 = 1'b0, U4 = 1'b0;
  logic       D1 = 1'b0, D2 = 1'b0, D3 = 1'b0, D4 = 1'b0;
  logic       F1 = 1'b0, F2 = 1'b0, F3 = 1'b0, F4 = 1'b0;
  logic       up, down, stop, open_door;
  logic [1:0] floor;
  logic [3:0] clr;
  int         checks = 0;
  int         errors = 0;

  elevator_fsm #(.DOOR_CYCLES(8), .IDLE_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4),
    .U1(U1), .U2(U2), .U3(U3), .U4(U4),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .F1(F1), .F2(F2), .F3(F3), .F4(F4),
    .up(up), .down(down), .stop(stop), .open_door(open_door),
    .floor(floor), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Output vector order below is {up, down, stop, open_door}.
  task automatic test_reset();
    ticks(2);
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd0 || clr !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got udso=%b floor=%0d clr=%b want 0010 0 0000", {up, down, stop, open_door}, floor, clr);
    end
  endtask

  task automatic test_init_locate();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0100) begin
        errors++;
        $display("FAIL init_search got udso=%b want 0100", {up, down, stop, open_door});
      end
    end
    S1 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd0) begin
      errors++;
      $display("FAIL init_found got udso=%b floor=%0d want 0010 0", {up, down, stop, open_door}, floor);
    end
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || clr !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold got udso=%b clr=%b want 0010 0000", {up, down, stop, open_door}, clr);
    end
  endtask

  task automatic test_single_stop();
    F3 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b1000) begin
      errors++;
      $display("FAIL depart_up got udso=%b want 1000", {up, down, stop, open_door});
    end
    S1 = 1'b0;
    tick();
    S2 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b1000 || floor !== 2'd1) begin
      errors++;
      $display("FAIL pass_floor1 got udso=%b floor=%0d want 1000 1", {up, down, stop, open_door}, floor);
    end
    S2 = 1'b0; S3 = 1'b1;
    tick();
    F3 = 1'b0;
    checks++;
    if ({up, down, stop, open_door} !== 4'b0011 || floor !== 2'd2 || clr !== 4'b0100) begin
      errors++;
      $display("FAIL arrive_floor2 got udso=%b floor=%0d clr=%b want 0011 2 0100", {up, down, stop, open_door}, floor, clr);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0011 || clr !== 4'b0100) begin
        errors++;
        $display("FAIL door_hold cycle %0d got udso=%b clr=%b want 0011 0100", i, {up, down, stop, open_door}, clr);
      end
    end
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || clr !== 4'b0000) begin
      errors++;
      $display("FAIL door_close got udso=%b clr=%b want 0010 0000", {up, down, stop, open_door}, clr);
    end
  endtask

  task automatic test_absorb();
    F3 = 1'b1;
    tick();
    F3 = 1'b0;
    checks++;
    if ({up, down, stop, open_door} !== 4'b0011 || clr !== 4'b0100) begin
      errors++;
      $display("FAIL idle_open got udso=%b clr=%b want 0011 0100", {up, down, stop, open_door}, clr);
    end
    for (int i = 1; i < 8; i++) begin
      U3 = (i == 3) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0011 || clr !== 4'b0100) begin
        errors++;
        $display("FAIL absorb_hold cycle %0d got udso=%b clr=%b want 0011 0100", i, {up, down, stop, open_door}, clr);
      end
    end
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || clr !== 4'b0000) begin
      errors++;
      $display("FAIL absorb_no_extend got udso=%b clr=%b want 0010 0000", {up, down, stop, open_door}, clr);
    end
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010) begin
      errors++;
      $display("FAIL absorb_no_reopen got udso=%b want 0010", {up, down, stop, open_door});
    end
  endtask

  task automatic test_move_down();
    F1 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100) begin
      errors++;
      $display("FAIL depart_down got udso=%b want 0100", {up, down, stop, open_door});
    end
    S3 = 1'b0;
    tick();
    S2 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100 || floor !== 2'd1) begin
      errors++;
      $display("FAIL down_pass1 got udso=%b floor=%0d want 0100 1", {up, down, stop, open_door}, floor);
    end
    S2 = 1'b0; S1 = 1'b1;
    tick();
    F1 = 1'b0;
    checks++;
    if ({up, down, stop, open_door} !== 4'b0011 || floor !== 2'd0 || clr !== 4'b0001) begin
      errors++;
      $display("FAIL arrive_floor0 got udso=%b floor=%0d clr=%b want 0011 0 0001", {up, down, stop, open_door}, floor, clr);
    end
    ticks(8);
  endtask

  task automatic test_reverse();
    F4 = 1'b1; D2 = 1'b1;
    tick();
    S1 = 1'b0; S2 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b1000 || floor !== 2'd1) begin
      errors++;
      $display("FAIL skip_down_call got udso=%b floor=%0d want 1000 1", {up, down, stop, open_door}, floor);
    end
    S2 = 1'b0; S3 = 1'b1;
    tick();
    S3 = 1'b0; S4 = 1'b1;
    tick();
    F4 = 1'b0;
    checks++;
    if ({up, down, stop, open_door} !== 4'b0011 || floor !== 2'd3 || clr !== 4'b1000) begin
      errors++;
      $display("FAIL arrive_top got udso=%b floor=%0d clr=%b want 0011 3 1000", {up, down, stop, open_door}, floor, clr);
    end
    ticks(9);
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100) begin
      errors++;
      $display("FAIL reverse_down got udso=%b want 0100", {up, down, stop, open_door});
    end
    S4 = 1'b0; S3 = 1'b1;
    tick();
    S3 = 1'b0; S2 = 1'b1;
    tick();
    D2 = 1'b0;
    checks++;
    if ({up, down, stop, open_door} !== 4'b0011 || floor !== 2'd1 || clr !== 4'b0010) begin
      errors++;
      $display("FAIL serve_down_call got udso=%b floor=%0d clr=%b want 0011 1 0010", {up, down, stop, open_door}, floor, clr);
    end
    ticks(8);
  endtask

  task automatic test_multi_sensor();
    F4 = 1'b1;
    tick();
    S2 = 1'b0; S3 = 1'b1; S4 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b1000 || floor !== 2'd1) begin
      errors++;
      $display("FAIL multi_ignored got udso=%b floor=%0d want 1000 1", {up, down, stop, open_door}, floor);
    end
    S4 = 1'b0;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b1000 || floor !== 2'd2) begin
      errors++;
      $display("FAIL multi_recover got udso=%b floor=%0d want 1000 2", {up, down, stop, open_door}, floor);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd0 || clr !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid got udso=%b floor=%0d clr=%b want 0010 0 0000", {up, down, stop, open_door}, floor, clr);
    end
    F4 = 1'b0; S3 = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100) begin
      errors++;
      $display("FAIL relocate got udso=%b want 0100", {up, down, stop, open_door});
    end
    S1 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd0) begin
      errors++;
      $display("FAIL relocated got udso=%b floor=%0d want 0010 0", {up, down, stop, open_door}, floor);
    end
  endtask

  task automatic test_home();
    F3 = 1'b1;
    tick();
    S1 = 1'b0; S2 = 1'b1;
    tick();
    S2 = 1'b0; S3 = 1'b1;
    tick();
    F3 = 1'b0;
    ticks(8);
    checks++;
    if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd2) begin
      errors++;
      $display("FAIL home_setup got udso=%b floor=%0d want 0010 2", {up, down, stop, open_door}, floor);
    end
`ifdef ELEV_HOME_RETURN_EN
    for (int i = 1; i < 64; i++) begin
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0010) begin
        errors++;
        $display("FAIL home_wait cycle %0d got udso=%b want 0010", i, {up, down, stop, open_door});
      end
    end
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100) begin
      errors++;
      $display("FAIL home_start got udso=%b want 0100", {up, down, stop, open_door});
    end
    S3 = 1'b0;
    tick();
    S2 = 1'b1;
    tick();
    checks++;
    if ({up, down, stop, open_door} !== 4'b0100 || floor !== 2'd1) begin
      errors++;
      $display("FAIL home_pass1 got udso=%b floor=%0d want 0100 1", {up, down, stop, open_door}, floor);
    end
    S2 = 1'b0; S1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd0 || clr !== 4'b0000) begin
        errors++;
        $display("FAIL home_arrive cycle %0d got udso=%b floor=%0d clr=%b want 0010 0 0000", i, {up, down, stop, open_door}, floor, clr);
      end
    end
`else
    for (int i = 0; i < 80; i++) begin
      tick();
      checks++;
      if ({up, down, stop, open_door} !== 4'b0010 || floor !== 2'd2) begin
        errors++;
        $display("FAIL no_home cycle %0d got udso=%b floor=%0d want 0010 2", i, {up, down, stop, open_door}, floor);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init_locate();
    test_single_stop();
    test_absorb();
    test_move_down();
    test_reverse();
    test_multi_sensor();
    test_reset_mid();
    test_home();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_fsm.md
ELEVATOR_FSM -- requirements
Module: elevator_fsm

Interface
REQ-001 Parameter DOOR_CYCLES, default 8: clock cycles the door stays open per stop.
REQ-002 Parameter IDLE_CYCLES, default 64: idle cycles before the home return (only used with ELEV_HOME_RETURN_EN).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Ports S1..S4, input, 1 each: floor sensors; high while the car is level with floor 1..4.
REQ-006 Ports U1..U4, D1..D4, F1..F4, input, 1 each: latched hall-up, hall-down and cab requests, one per floor.
REQ-007 Ports up, down, stop, output, 1 each: motor commands; exactly one is high in every cycle.
REQ-008 Port open_door, output, 1: door open command.
REQ-009 Port floor, output, 2: last sensed floor (0 = floor 1 ... 3 = floor 4).
REQ-010 Port clr, output, 4: one-hot acknowledge telling the upstream latch stage to clear the U/D/F requests of that floor.

Function
REQ-011 All outputs shall be registered.
- pend[k] = U|D|F of floor k.
- above = any pend on a floor higher than floor; below = any pend on a floor lower than floor.
REQ-012 States shall be INIT, IDLE, MOVE_UP, MOVE_DOWN, DOOR.
REQ-013 INIT behaviour:
- no sensor high: down=1.
- any single sensor high: load floor from it, stop=1, next state IDLE.
REQ-014 IDLE behaviour: stop=1; floor tracks any single asserted sensor. Priority of decisions:
- pend[floor]: DOOR.
- otherwise, requests on the side of the dir register: move that way.
- otherwise, requests on the opposite side: move that way.
- otherwise: stay in IDLE.
REQ-015 MOVE_UP behaviour: up=1, dir=up. A sensor for floor k != floor updates floor to k. Stop (next state DOOR) when any of:
- F[k] or U[k];
- no requests above k;
- k = 3.
REQ-016 MOVE_DOWN shall mirror MOVE_UP:
- stop on F[k] or D[k], or no requests below k, or k = 0;
- dir=down.
REQ-017 DOOR behaviour:
- outputs: stop=1, open_door=1, clr[floor]=1 every cycle in DOOR.
- timer runs DOOR_CYCLES cycles, then next state IDLE.
- door is closed again by the cycle after exit.
REQ-018 Requests at the current floor that arrive during DOOR shall be absorbed by clr and shall not restart the timer.
REQ-019 A sensor sample with more than one sensor high shall be ignored: no floor update, motion continues.
REQ-020 Latency: a sensor edge at a stop floor shall give stop=1 and open_door=1 on the next rising clk.
REQ-021 clr shall be 0 in every state except DOOR.

Reset
REQ-022 While reset is low at a rising edge, the following shall load:
- state=INIT, floor=0, dir=up;
- stop=1, up=0, down=0, open_door=0, clr=0;
- timers=0.
REQ-023 Reset mid-motion or mid-door shall abandon the operation. After release, INIT re-locates the car.

Configuration
REQ-024 With macro ELEV_HOME_RETURN_EN defined:
- home return starts after IDLE_CYCLES consecutive IDLE cycles with no pend and floor != 0.
- the car moves down to floor 0 and stops in IDLE without opening the door.
- any new request aborts the return and is served normally.
REQ-025 Without ELEV_HOME_RETURN_EN, IDLE holds indefinitely and the idle counter is absent.

Verification
REQ-026 Reset low, then release with all sensors low -> down=1 until S1 pulses -> stop=1, floor=0, state IDLE.
REQ-027 Car at floor 0, F3 set -> up=1; S2 passes with no stop; S3 high -> next edge stop=1, open_door=1, clr=4'b0100 for 8 cycles.
REQ-028 Car moving up from floor 0 with F4 and D2 set -> no stop at floor 1; stop at floor 3; then down to floor 1 and open there.
REQ-029 Car at floor 2 with U3 set during DOOR -> clr absorbs the request; timer not extended; IDLE after 8 cycles.
REQ-030 Reset low mid-travel with up=1 -> next edge stop=1, up=0, open_door=0, state INIT.
REQ-031 With ELEV_HOME_RETURN_EN: car idle at floor 2 for 64 cycles -> down=1, stops at S1 with open_door never asserted. Without the macro -> remains stopped at floor 2.
